i_cache_nway: RTL and testbench
===============================

// Module: i_cache_nway
// PURPOSE
//  Parametrised N-way set-associative, read-only instruction cache. Sits between the IF stage and
//  instruction memory. Successor of the direct-mapped single-word i-cache: adds multi-word blocks
//  with word select, 1/2/4 ways, round-robin replacement and a fence.i flush sweep.
//  Hit returns in the same cycle; a miss stalls the CPU and refills a whole block from memory.
// PARAMETERS
//  BLOCK_SIZE  4    words (32-bit) per block; power of 2, >=1
//  ENTRIES     64   sets; power of 2, >=2
//  WAYS        2    associativity; 1, 2 or 4
// PORTS
//  i_clk        in   1               clock
//  i_rst        in   1               synchronous reset, active-high
//  i_DataBlock  in   BLOCK_SIZE*32   refill block from memory; word 0 in bits [31:0]
//  i_MemReady   in   1               i_DataBlock valid this cycle (sampled only while o_DataReq=1)
//  o_DataReq    out  1               refill request, held until i_MemReady
//  o_MemAddr    out  XLEN            block-aligned refill address
//  i_Addr       in   XLEN            fetch address; CPU holds it stable while o_Stall=1
//  i_Flush      in   1               single-cycle pulse: invalidate all lines (fence.i)
//  o_Data       out  32              fetched instruction; 0 when not hit
//  o_Stall      out  1               CPU must not advance
//  o_HitCnt     out  32              hits, present only with ICACHE_PERF_CNT_EN
//  o_MissCnt    out  32              misses, present only with ICACHE_PERF_CNT_EN
// BEHAVIOUR
//  Address fields: M=log2(BLOCK_SIZE), N=log2(ENTRIES). Word=i_Addr[2+:M] (absent when M=0),
//   index=i_Addr[M+2+:N], tag=upper XLEN-(N+M+2) bits. o_MemAddr={i_Addr[XLEN-1:M+2],(M+2)'b0}.
//  FSM states: COMPARE_TAG, ALLOCATE, FLUSH. Reset: state=COMPARE_TAG, all valid=0, rr ptrs=0,
//   counters=0, o_DataReq=0, o_Stall=1, o_Data=0 while i_rst=1.
//  COMPARE_TAG: hit = some way with valid && tag match; at most one way matches.
//   Hit: o_Stall=0 and o_Data = matching way's word, same cycle.
//   Miss: o_Stall=1 and next state is ALLOCATE. i_Flush=1 has priority: next state is FLUSH.
//  ALLOCATE: o_DataReq=1, o_Stall=1. When i_MemReady=1, the block is written to the victim way.
//   The write sets valid and tag, and the rr pointer of that set advances when the victim came from it.
//   Next state is COMPARE_TAG, which hits one cycle later. Minimum miss penalty: 2 stall cycles plus
//   memory latency.
//  Victim: the lowest-numbered invalid way in the set, else the set's rr pointer (mod WAYS).
//  Flush during ALLOCATE: latched into flush_pend. The refill completes and is written, then the FSM
//   goes to FLUSH instead of COMPARE_TAG.
//  FLUSH: o_Stall=1 and o_DataReq=0. An index counter sweeps sets 0..ENTRIES-1, clearing all ways'
//   valid bits and rr pointers, one set per cycle (ENTRIES cycles). Then the FSM returns to
//   COMPARE_TAG. i_Flush during FLUSH is ignored.
//  Reset asserted mid-refill or mid-sweep: the FSM returns to COMPARE_TAG at once and all lines are
//   invalid. A late i_MemReady is ignored.
//  WAYS=1 degenerates to direct-mapped; the rr pointer is unused and tied to 0.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: o_HitCnt increments on each COMPARE_TAG cycle with a hit.
//   o_MissCnt increments on each COMPARE_TAG->ALLOCATE transition. Both wrap at 2^32, reset to 0,
//   and are not cleared by flush.
//  Not defined: the counters and ports are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package arvi_cache_pkg: the icache_state_t enum (COMPARE_TAG/ALLOCATE/FLUSH), and width helper
//   functions for index/offset/tag.
//  Sub-module i_cache_way: one per way (generate loop). Holds the valid/tag/data arrays and has a
//   write port for refill/flush. It outputs match and the selected word for the given index/tag/word.
//  The top level holds the FSM, victim select, rr pointers, flush counter, hit/data mux and the
//   optional counters.
// TESTING (BLOCK_SIZE=4, ENTRIES=64, WAYS=2, memory latency 3 cycles)
//  Cold fetch 0x100 -> o_Stall=1, o_DataReq=1 with o_MemAddr=0x100. Refill {D3,D2,D1,D0} is written.
//   Next COMPARE_TAG hit gives o_Data=D0. Then 0x104/0x108/0x10C -> D1/D2/D3, no stall.
//  Fill 0x100 (way0) then 0x500 (way1), same set 16 -> both hit. Then 0x900 evicts way0 (rr=0) ->
//   0x100 misses and 0x500 still hits.
//  Hit on 0x100, then pulse i_Flush -> 64 stall cycles with o_DataReq=0 -> 0x100 misses again.
//  Pulse i_Flush while ALLOCATE waits for i_MemReady -> the refill completes, FLUSH follows,
//   and the refilled line is invalid.
//  Assert i_rst during ALLOCATE, then give i_MemReady after release -> o_DataReq=0,
//   and no line becomes valid.
//  With ICACHE_PERF_CNT_EN: 3 misses + 5 hits -> o_MissCnt=3, o_HitCnt=5. Without the macro:
//   the bench compiles without the counter ports.

Source files
------------

// File: rtl/arvi_cache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
// Build option: ICACHE_PERF_CNT_EN adds hit/miss counters to i_cache_nway.
package arvi_cache_pkg;

  typedef enum logic [1:0] {
    COMPARE_TAG = 2'd0,
    ALLOCATE    = 2'd1,
    FLUSH       = 2'd2
  } icache_state_t;

  // ceil(log2(v)), 0 for v<=1
  function automatic int log2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  // word-select bits inside a block
  function automatic int offset_bits(input int block_size);
    return log2_int(block_size);
  endfunction

  // set-index bits
  function automatic int index_bits(input int entries);
    return log2_int(entries);
  endfunction

  // tag bits left above index, word select and byte offset
  function automatic int tag_bits(input int xlen, input int entries, input int block_size);
    return xlen - index_bits(entries) - offset_bits(block_size) - 2;
  endfunction

  // round-robin pointer width (at least one bit so the vector exists)
  function automatic int rr_bits(input int ways);
    return (ways > 1) ? log2_int(ways) : 1;
  endfunction

endpackage

// File: rtl/i_cache_way.sv
// One way of the instruction cache: valid/tag/data arrays with a refill
// write port and a per-set invalidate port. Reads are combinational.
module i_cache_way
  import arvi_cache_pkg::*;
#(
  parameter int BLOCK_SIZE = 4,
  parameter int ENTRIES    = 64,
  parameter int IW         = 6,
  parameter int TW         = 22,
  parameter int WW         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IW-1:0]           rd_idx,
  input  logic [TW-1:0]           rd_tag,
  input  logic [WW-1:0]           rd_word,
  input  logic                    fill,
  input  logic                    clr,
  input  logic [IW-1:0]           wr_idx,
  input  logic [TW-1:0]           wr_tag,
  input  logic [BLOCK_SIZE*32-1:0] wr_block,
  output logic                    valid,
  output logic                    match,
  output logic [31:0]             word
);

  logic [ENTRIES-1:0]          valid_r;
  logic [TW-1:0]               tag_r  [ENTRIES];
  logic [BLOCK_SIZE-1:0][31:0] data_r [ENTRIES];

  // valid bits: cleared by reset, set by refill, cleared by the flush sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill) begin
      valid_r[wr_idx] <= 1'b1;
    end else if (clr) begin
      valid_r[wr_idx] <= 1'b0;
    end
  end

  // tag and data storage, written only on refill (no reset needed)
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_block;
    end
  end

  // lookup for the current fetch address
  always_comb begin
    valid = valid_r[rd_idx];
    match = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    word  = data_r[rd_idx][rd_word];
  end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative read-only instruction cache with round-robin
// replacement and a fence.i flush sweep.
// Build option: define ICACHE_PERF_CNT_EN to add o_HitCnt/o_MissCnt.
module i_cache_nway
  import arvi_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ENTRIES    = 64,
  parameter int WAYS       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [BLOCK_SIZE*32-1:0] i_DataBlock,
  input  logic                     i_MemReady,
  output logic                     o_DataReq,
  output logic [XLEN-1:0]          o_MemAddr,
  input  logic [XLEN-1:0]          i_Addr,
  input  logic                     i_Flush,
  output logic [31:0]              o_Data,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]              o_HitCnt,
  output logic [31:0]              o_MissCnt,
`endif
  output logic                     o_Stall
);

  localparam int M  = offset_bits(BLOCK_SIZE);
  localparam int N  = index_bits(ENTRIES);
  localparam int TW = tag_bits(XLEN, ENTRIES, BLOCK_SIZE);
  localparam int RW = rr_bits(WAYS);
  localparam int WW = (M > 0) ? M : 1;

  icache_state_t state_r;
  logic          flush_pend_r;
  logic          data_req_r;
  logic [N-1:0]  flush_idx_r;
  logic [RW-1:0] rr_r [ENTRIES];

  logic [N-1:0]            idx_s;
  logic [TW-1:0]           tag_s;
  logic [WW-1:0]           word_s;
  logic [WAYS-1:0]         valid_s;
  logic [WAYS-1:0]         match_s;
  logic [WAYS-1:0][31:0]   rd_word_s;
  logic [WAYS-1:0]         fill_way_s;
  logic                    hit_any_s;
  logic [31:0]             hit_word_s;
  logic [RW-1:0]           victim_s;
  logic                    any_invalid_s;
  logic                    fill_s;
  logic                    clr_s;
  logic [N-1:0]            wr_idx_s;
  logic                    unused_addr_s;

  assign idx_s         = i_Addr[M+2 +: N];
  assign tag_s         = i_Addr[XLEN-1 -: TW];
  assign o_MemAddr     = {i_Addr[XLEN-1:M+2], {(M+2){1'b0}}};
  assign unused_addr_s = ^i_Addr[1:0];

  generate
    if (M > 0) begin : g_word
      assign word_s = i_Addr[2 +: WW];
    end else begin : g_noword
      assign word_s = '0;
    end
  endgenerate

  // refill happens only on the accepted memory beat; the sweep clears one set per cycle
  assign fill_s   = (state_r == ALLOCATE) && i_MemReady && !i_rst;
  assign clr_s    = (state_r == FLUSH);
  assign wr_idx_s = clr_s ? flush_idx_r : idx_s;

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign fill_way_s[w] = fill_s && (victim_s == RW'(w));
      i_cache_way #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ENTRIES    (ENTRIES),
        .IW         (N),
        .TW         (TW),
        .WW         (WW)
      ) u_way (
        .clk      (i_clk),
        .rst      (i_rst),
        .rd_idx   (idx_s),
        .rd_tag   (tag_s),
        .rd_word  (word_s),
        .fill     (fill_way_s[w]),
        .clr      (clr_s),
        .wr_idx   (wr_idx_s),
        .wr_tag   (tag_s),
        .wr_block (i_DataBlock),
        .valid    (valid_s[w]),
        .match    (match_s[w]),
        .word     (rd_word_s[w])
      );
    end
  endgenerate

  // hit detect and word mux (at most one way matches, so OR-ing is exact)
  always_comb begin
    hit_any_s  = |match_s;
    hit_word_s = 32'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (match_s[w]) begin
        hit_word_s = hit_word_s | rd_word_s[w];
      end else begin
        hit_word_s = hit_word_s;
      end
    end
  end

  // victim: lowest-numbered invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim_s      = rr_r[idx_s];
    any_invalid_s = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_s[w]) begin
        victim_s      = RW'(w);
        any_invalid_s = 1'b1;
      end else begin
        victim_s      = victim_s;
      end
    end
  end

  // CPU-facing outputs: same-cycle hit, forced stall and zero data in reset
  always_comb begin
    o_DataReq = data_req_r && !i_rst;
    if (!i_rst && (state_r == COMPARE_TAG) && hit_any_s) begin
      o_Stall = 1'b0;
      o_Data  = hit_word_s;
    end else begin
      o_Stall = 1'b1;
      o_Data  = 32'd0;
    end
  end

  // control FSM: tag compare, block refill and flush sweep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= COMPARE_TAG;
      flush_pend_r <= 1'b0;
      data_req_r   <= 1'b0;
      flush_idx_r  <= '0;
    end else begin
      case (state_r)
        COMPARE_TAG: begin
          if (i_Flush) begin
            state_r     <= FLUSH;
            flush_idx_r <= '0;
          end else if (!hit_any_s) begin
            state_r    <= ALLOCATE;
            data_req_r <= 1'b1;
          end else begin
            state_r <= COMPARE_TAG;
          end
        end
        ALLOCATE: begin
          if (i_MemReady) begin
            data_req_r   <= 1'b0;
            flush_pend_r <= 1'b0;
            flush_idx_r  <= '0;
            // a flush seen while waiting still lets the refill land, then sweeps
            state_r      <= (flush_pend_r || i_Flush) ? FLUSH : COMPARE_TAG;
          end else if (i_Flush) begin
            flush_pend_r <= 1'b1;
          end else begin
            flush_pend_r <= flush_pend_r;
          end
        end
        FLUSH: begin
          if (flush_idx_r == N'(ENTRIES - 1)) begin
            state_r     <= COMPARE_TAG;
            flush_idx_r <= '0;
          end else begin
            flush_idx_r <= flush_idx_r + N'(1);
          end
        end
        default: begin
          state_r      <= COMPARE_TAG;
          flush_pend_r <= 1'b0;
          data_req_r   <= 1'b0;
          flush_idx_r  <= '0;
        end
      endcase
    end
  end

  // round-robin pointers: advance only when the victim came from the pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int e = 0; e < ENTRIES; e++) rr_r[e] <= '0;
    end else if (clr_s) begin
      rr_r[flush_idx_r] <= '0;
    end else if (fill_s && !any_invalid_s && (WAYS > 1)) begin
      rr_r[idx_s] <= rr_r[idx_s] + RW'(1);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // performance counters: hits per compare cycle, misses per compare->allocate
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_HitCnt  <= 32'd0;
      o_MissCnt <= 32'd0;
    end else if (state_r == COMPARE_TAG) begin
      if (hit_any_s) begin
        o_HitCnt <= o_HitCnt + 32'd1;
      end else if (!i_Flush) begin
        o_MissCnt <= o_MissCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_cache_nway.sv
// Self-checking bench for i_cache_nway (BLOCK_SIZE=4, ENTRIES=64, WAYS=2,
// memory latency 3 cycles). Counter checks are compiled in only when
// ICACHE_PERF_CNT_EN is defined.
module tb_i_cache_nway;

  logic         clk;
  logic         rst;
  logic [127:0] data_block;
  logic         mem_ready;
  logic         data_req;
  logic [31:0]  mem_addr;
  logic [31:0]  addr;
  logic         flush;
  logic [31:0]  data;
  logic         stall;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  i_cache_nway #(.XLEN(32), .BLOCK_SIZE(4), .ENTRIES(64), .WAYS(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_DataBlock (data_block),
    .i_MemReady  (mem_ready),
    .o_DataReq   (data_req),
    .o_MemAddr   (mem_addr),
    .i_Addr      (addr),
    .i_Flush     (flush),
    .o_Data      (data),
`ifdef ICACHE_PERF_CNT_EN
    .o_HitCnt    (hit_cnt),
    .o_MissCnt   (miss_cnt),
`endif
    .o_Stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ref_hits = 0;
  int ref_misses = 0;
  logic [31:0] salt;

  // reference model: per-set resident tags, valid flags and rr pointer
  bit          ref_valid [64][2];
  logic [21:0] ref_tag   [64][2];
  int          ref_rr    [64];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [127:0] block_at(input logic [31:0] a);
    logic [31:0]  base;
    logic [127:0] b;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = word_at(base + 32'(4 * i));
    return b;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'((a >> 4) & 32'h3F);
    for (int w = 0; w < 2; w++)
      if (ref_valid[s][w] && ref_tag[s][w] == a[31:10]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s, v;
    s = int'((a >> 4) & 32'h3F);
    if (!ref_valid[s][0]) v = 0;
    else if (!ref_valid[s][1]) v = 1;
    else begin
      v = ref_rr[s];
      ref_rr[s] = (ref_rr[s] + 1) % 2;
    end
    ref_valid[s][v] = 1'b1;
    ref_tag[s][v]   = a[31:10];
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      ref_valid[s][0] = 1'b0;
      ref_valid[s][1] = 1'b0;
      ref_rr[s] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // called at a negedge in the first ALLOCATE cycle; memory answers in the third
  task automatic serve_alloc(input logic [31:0] a);
    chk("alloc_req", {31'd0, data_req}, 32'd1);
    chk("alloc_stall", {31'd0, stall}, 32'd1);
    chk("alloc_addr", mem_addr, a & 32'hFFFF_FFF0);
    @(negedge clk);
    @(negedge clk);
    chk("alloc_req_held", {31'd0, data_req}, 32'd1);
    mem_ready  = 1'b1;
    data_block = block_at(a);
    @(negedge clk);
    mem_ready  = 1'b0;
    data_block = {4{$urandom}};
    model_fill(a);
    #1;
    chk("refill_hit_stall", {31'd0, stall}, 32'd0);
    chk("refill_hit_data", data, word_at(a));
    ref_hits++;
    @(negedge clk);
  endtask

  // one fetch from a negedge in COMPARE_TAG; returns at the next free negedge
  task automatic fetch(input logic [31:0] a);
    addr = a;
    #1;
    if (model_hit(a)) begin
      chk("hit_stall", {31'd0, stall}, 32'd0);
      chk("hit_data", data, word_at(a));
      ref_hits++;
      @(negedge clk);
    end else begin
      chk("miss_stall", {31'd0, stall}, 32'd1);
      chk("miss_data", data, 32'd0);
      ref_misses++;
      @(negedge clk);
      serve_alloc(a);
    end
  endtask

  // 64 sweep cycles: stalled, no memory request
  task automatic check_sweep();
    for (int k = 0; k < 64; k++) begin
      if (k == 10) flush = 1'b1;
      else flush = 1'b0;
      #1;
      chk("sweep_stall", {31'd0, stall}, 32'd1);
      chk("sweep_req", {31'd0, data_req}, 32'd0);
      @(negedge clk);
    end
    flush = 1'b0;
    model_clear();
  endtask

  task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
    chk({tag, "_hits"}, hit_cnt, 32'(ref_hits));
    chk({tag, "_misses"}, miss_cnt, 32'(ref_misses));
`else
    if (tag.len() == 0) $display("counter note: %s", tag);
`endif
  endtask

  initial begin
    salt       = $urandom;
    rst        = 1'b1;
    mem_ready  = 1'b0;
    flush      = 1'b0;
    addr       = 32'h0000_0100;
    data_block = 128'd0;
    model_clear();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_data", data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_counters("after_reset");

    // cold miss then word-select hits within the block
    fetch(32'h0000_0100);
    fetch(32'h0000_0104);
    fetch(32'h0000_0108);
    fetch(32'h0000_010C);

    // same set 16: fill both ways, then evict by round robin
    fetch(32'h0000_0500);
    fetch(32'h0000_0100);
    fetch(32'h0000_0504);
    fetch(32'h0000_0900);
    fetch(32'h0000_0500);
    fetch(32'h0000_0100);
    check_counters("set16");

    // hit with flush pulse, full sweep, then the line misses again
    fetch(32'h0000_0108);
    addr  = 32'h0000_0100;
    flush = 1'b1;
    #1;
    chk("flush_cycle_hit", {31'd0, stall}, 32'd0);
    ref_hits++;
    @(negedge clk);
    check_sweep();
    fetch(32'h0000_0100);

    // flush while the refill is outstanding
    addr = 32'h0000_2340;
    #1;
    chk("fa_miss", {31'd0, stall}, 32'd1);
    ref_misses++;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fa_req", {31'd0, data_req}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    mem_ready  = 1'b1;
    data_block = block_at(32'h0000_2340);
    @(negedge clk);
    mem_ready  = 1'b0;
    model_fill(32'h0000_2340);
    check_sweep();
    fetch(32'h0000_2340);
    fetch(32'h0000_2344);
    check_counters("after_flushes");

    // reset in the middle of a refill; late ready is ignored
    addr = 32'h0000_3000;
    #1;
    ref_misses++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_alloc_req", {31'd0, data_req}, 32'd0);
    chk("rst_alloc_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    mem_ready  = 1'b1;
    data_block = block_at(32'h0000_3000);
    model_clear();
    ref_hits   = 0;
    ref_misses = 0;
    #1;
    chk("late_ready_req", {31'd0, data_req}, 32'd0);
    chk("late_ready_stall", {31'd0, stall}, 32'd1);
    ref_misses++;
    @(negedge clk);
    mem_ready = 1'b0;
    serve_alloc(32'h0000_3000);
    fetch(32'h0000_2340);
    fetch(32'h0000_0100);
    check_counters("after_mid_reset");

    // randomized fetches over three conflicting sets and four tags each
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 2));
      a = (32'($urandom_range(0, 3)) << 10)
        | (32'((sel == 0) ? 5 : (sel == 1) ? 16 : 17) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      fetch(a);
    end
    check_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
